// File: rtl/jtag_wb_ram_slave_if.sv
// jtag_wb_ram_slave_if: classic Wishbone slave-side bus bundle for the RAM slave
interface jtag_wb_ram_slave_if #(
  parameter int DW   = 32,
  parameter int M_Aw = 32,
  parameter int SELw = 4,
  parameter int TAGw = 3
);
  logic [DW-1:0]   s_dat_i;
  logic [SELw-1:0] s_sel_i;
  logic [M_Aw-1:0] s_addr_i;
  logic [TAGw-1:0] s_cti_i;
  logic            s_stb_i;
  logic            s_cyc_i;
  logic            s_we_i;
  logic [DW-1:0]   s_dat_o;
  logic            s_ack_o;
  modport master (
    output s_dat_i, s_sel_i, s_addr_i, s_cti_i, s_stb_i, s_cyc_i, s_we_i,
    input  s_dat_o, s_ack_o
  );
  modport slave (
    input  s_dat_i, s_sel_i, s_addr_i, s_cti_i, s_stb_i, s_cyc_i, s_we_i,
    output s_dat_o, s_ack_o
  );
endinterface

// File: rtl/jtag_wb_ram_slave.sv
// jtag_wb_ram_slave: Wishbone RAM slave with wait states, saturating access counters and sticky out-of-range flag
module jtag_wb_ram_slave #(
  parameter int DW          = 32,
  parameter int Aw          = 7,
  parameter int M_Aw        = 32,
  parameter int DEPTH       = 128,
  parameter int SELw        = 4,
  parameter int TAGw        = 3,
  parameter int WAIT_CYCLES = 0,
  parameter int SW          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  jtag_wb_ram_slave_if.slave   s,
  output logic [SW-1:0]        status_o
);
  localparam int RW = SW / 2;
  localparam int WW = SW / 2 - 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  localparam logic [Aw:0] DEPTH_W = (Aw + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [WW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            oob_q, oob_d;
  logic            run_q;
  logic            req, fire, in_range;
  logic [Aw-1:0]   idx;
  logic [DW-1:0]   mem [DEPTH];
  logic            unused_cti;
  assign unused_cti = ^s.s_cti_i;
  assign idx        = s.s_addr_i[Aw-1:0];
  assign s.s_ack_o  = ack_q;
  assign s.s_dat_o  = dat_q;
  assign status_o   = {oob_q, wr_cnt_q, rd_cnt_q};
  // Next-state: request recognition, wait countdown, read capture and counter updates.
  // run_q keeps requests from being served on an edge where reset is still held.
  always_comb begin
    req      = s.s_stb_i && s.s_cyc_i && run_q;
    in_range = ((s.s_addr_i >> Aw) == '0) && ({1'b0, idx} < DEPTH_W);
    fire     = req && ((state_q == IDLE && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == '0));
    state_d  = fire ? ACK : (req && state_q != ACK) ? WAIT : IDLE;
    cnt_d    = (state_q == IDLE && req) ? CNT_INIT : (state_q == WAIT) ? cnt_q - 4'd1 : '0;
    ack_d    = fire;
    dat_d    = (fire && !s.s_we_i) ? (in_range ? mem[idx] : '0) : dat_q;
    wr_cnt_d = wr_cnt_q + WW'(fire && s.s_we_i && !(&wr_cnt_q));
    rd_cnt_d = rd_cnt_q + RW'(fire && !s.s_we_i && !(&rd_cnt_q));
    oob_d    = oob_q || (fire && !in_range);
  end
  // Control state, registered bus outputs and status, all cleared by async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      oob_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      oob_q    <= oob_d;
      run_q    <= 1'b1;
    end
  end
  // RAM byte-lane writes on ACK entry; out-of-range writes are dropped, contents never reset.
  always_ff @(posedge clk) begin
    if (fire && s.s_we_i && in_range)
      for (int b = 0; b < SELw; b++)
        if (s.s_sel_i[b]) mem[idx][b*8 +: 8] <= s.s_dat_i[b*8 +: 8];
  end
endmodule

// File: tb/tb_jtag_wb_ram_slave.sv
// tb_jtag_wb_ram_slave: directed vector bench across three RAM slave configurations
module tb_jtag_wb_ram_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int          dsel = 0;
  logic        cyc = 0, stb = 0, we = 0;
  logic [31:0] addr = '0, dat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] st_a, st_b;
  logic [3:0]  st_c;
  logic        ack_m;
  logic [31:0] dat_m, st_m;
  int cmp = 0, bad = 0;
  jtag_wb_ram_slave_if ifa();
  jtag_wb_ram_slave_if ifb();
  jtag_wb_ram_slave_if ifc();
  assign ifa.s_dat_i = dat; assign ifa.s_sel_i = sel; assign ifa.s_addr_i = addr; assign ifa.s_cti_i = '0;
  assign ifa.s_stb_i = stb; assign ifa.s_we_i = we; assign ifa.s_cyc_i = cyc && dsel == 0;
  assign ifb.s_dat_i = dat; assign ifb.s_sel_i = sel; assign ifb.s_addr_i = addr; assign ifb.s_cti_i = '0;
  assign ifb.s_stb_i = stb; assign ifb.s_we_i = we; assign ifb.s_cyc_i = cyc && dsel == 1;
  assign ifc.s_dat_i = dat; assign ifc.s_sel_i = sel; assign ifc.s_addr_i = addr; assign ifc.s_cti_i = '0;
  assign ifc.s_stb_i = stb; assign ifc.s_we_i = we; assign ifc.s_cyc_i = cyc && dsel == 2;
  jtag_wb_ram_slave #(.DEPTH(100), .WAIT_CYCLES(0), .SW(32)) da (.clk(clk), .reset(reset), .s(ifa), .status_o(st_a));
  jtag_wb_ram_slave #(.DEPTH(128), .WAIT_CYCLES(3), .SW(32)) db (.clk(clk), .reset(reset), .s(ifb), .status_o(st_b));
  jtag_wb_ram_slave #(.DEPTH(128), .WAIT_CYCLES(0), .SW(4))  dc (.clk(clk), .reset(reset), .s(ifc), .status_o(st_c));
  assign ack_m = dsel == 0 ? ifa.s_ack_o : dsel == 1 ? ifb.s_ack_o : ifc.s_ack_o;
  assign dat_m = dsel == 0 ? ifa.s_dat_o : dsel == 1 ? ifb.s_dat_o : ifc.s_dat_o;
  assign st_m  = dsel == 0 ? st_a : dsel == 1 ? st_b : {28'd0, st_c};
  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  sl;
    int          lat;
    logic [31:0] rd;
    logic [31:0] st;
  } vec_t;
  vec_t t1 [12];
  vec_t t2 [9];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    logic [31:0] rd;
    logic dbl;
    @(posedge clk); #1;
    dsel = v.d; cyc = 1; stb = 1; we = v.w; addr = v.a; dat = v.wd; sel = v.sl;
    lat = -1; rd = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack_m) begin lat = i; rd = dat_m; break; end
    end
    @(posedge clk); #1;
    dbl = ack_m;
    stb = 0; cyc = 0; we = 0;
    check({nm, "_lat"}, 32'(lat), 32'(v.lat));
    if (!v.w) check({nm, "_rdata"}, rd, v.rd);
    check({nm, "_single_ack"}, {31'd0, dbl}, 32'd0);
    check({nm, "_status"}, st_m, v.st);
  endtask
  initial begin
    logic seen;
    t1[0]  = '{0, 1'b1, 32'd5,        32'hDEADBEEF, 4'hF, 1, 32'h0,        32'h00010000};
    t1[1]  = '{0, 1'b0, 32'd5,        32'h0,        4'hF, 1, 32'hDEADBEEF, 32'h00010001};
    t1[2]  = '{0, 1'b1, 32'd9,        32'h11223344, 4'hF, 1, 32'h0,        32'h00020001};
    t1[3]  = '{0, 1'b1, 32'd9,        32'hAABBCCDD, 4'h5, 1, 32'h0,        32'h00030001};
    t1[4]  = '{0, 1'b0, 32'd9,        32'h0,        4'hF, 1, 32'h11BB33DD, 32'h00030002};
    t1[5]  = '{0, 1'b1, 32'd120,      32'h5,        4'hF, 1, 32'h0,        32'h80040002};
    t1[6]  = '{0, 1'b0, 32'd120,      32'h0,        4'hF, 1, 32'h0,        32'h80040003};
    t1[7]  = '{0, 1'b0, 32'h80000000, 32'h0,        4'hF, 1, 32'h0,        32'h80040004};
    t1[8]  = '{0, 1'b1, 32'h85,       32'h12345678, 4'hF, 1, 32'h0,        32'h80050004};
    t1[9]  = '{0, 1'b0, 32'd5,        32'h0,        4'hF, 1, 32'hDEADBEEF, 32'h80050005};
    t1[10] = '{1, 1'b1, 32'd0,        32'hCAFEF00D, 4'hF, 4, 32'h0,        32'h00010000};
    t1[11] = '{1, 1'b0, 32'd0,        32'h0,        4'hF, 4, 32'hCAFEF00D, 32'h00010001};
    t2[0]  = '{1, 1'b0, 32'd0,        32'h0,        4'hF, 4, 32'hCAFEF00D, 32'h00000001};
    t2[1]  = '{0, 1'b0, 32'd5,        32'h0,        4'hF, 1, 32'hDEADBEEF, 32'h00000001};
    t2[2]  = '{2, 1'b1, 32'd1,        32'h00000077, 4'hF, 1, 32'h0,        32'h4};
    t2[3]  = '{2, 1'b1, 32'd1,        32'h00000077, 4'hF, 1, 32'h0,        32'h4};
    t2[4]  = '{2, 1'b0, 32'd1,        32'h0,        4'hF, 1, 32'h00000077, 32'h5};
    t2[5]  = '{2, 1'b0, 32'd1,        32'h0,        4'hF, 1, 32'h00000077, 32'h6};
    t2[6]  = '{2, 1'b0, 32'd1,        32'h0,        4'hF, 1, 32'h00000077, 32'h7};
    t2[7]  = '{2, 1'b0, 32'd1,        32'h0,        4'hF, 1, 32'h00000077, 32'h7};
    t2[8]  = '{2, 1'b0, 32'd1,        32'h0,        4'hF, 1, 32'h00000077, 32'h7};
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      dsel = d; #1;
      check($sformatf("rst%0d_ack", d), {31'd0, ack_m}, 32'd0);
      check($sformatf("rst%0d_dat", d), dat_m, 32'd0);
      check($sformatf("rst%0d_status", d), st_m, 32'd0);
    end
    reset = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 12; i++) run_vec($sformatf("t1_%0d", i), t1[i]);
    @(posedge clk); #1;
    dsel = 1; cyc = 1; stb = 1; we = 1; addr = 0; dat = 32'h0BADBAD0; sel = 4'hF;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; seen |= ack_m; end
    stb = 0; cyc = 0; we = 0;
    repeat (6) begin @(posedge clk); #1; seen |= ack_m; end
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    check("abort_wr_cnt", st_m, 32'h00010001);
    run_vec("after_abort", '{1, 1'b0, 32'd0, 32'h0, 4'hF, 4, 32'hCAFEF00D, 32'h00010002});
    run_vec("b2b_first", '{1, 1'b0, 32'd0, 32'h0, 4'hF, 4, 32'hCAFEF00D, 32'h00010003});
    dsel = 1; cyc = 1; stb = 1; we = 0; addr = 0;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; seen |= ack_m; end
    reset = 1;
    #1;
    check("rst_mid_ack", {31'd0, ack_m}, 32'd0);
    check("rst_mid_dat", dat_m, 32'd0);
    check("rst_mid_status", st_m, 32'd0);
    repeat (5) begin @(posedge clk); #1; seen |= ack_m; end
    check("rst_mid_no_ack", {31'd0, seen}, 32'd0);
    stb = 0; cyc = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 9; i++) run_vec($sformatf("t2_%0d", i), t2[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
